// File: rtl/cache_fill_responder_pkg.sv
// Shared constants and state encoding for the cache line fill responder.
package cache_fill_responder_pkg;

  localparam int LINE_WORDS    = 8;
  localparam int WORD_OFS_BITS = 3;
  localparam logic [WORD_OFS_BITS-1:0] LAST_SLOT = WORD_OFS_BITS'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    STREAM   = 3'd2,
    WRITE    = 3'd3,
    WAITDROP = 3'd4
  } state_t;

  // Word offset within a line wraps modulo the line size, never carrying out.
  function automatic logic [WORD_OFS_BITS-1:0] next_slot(input logic [WORD_OFS_BITS-1:0] slot);
    return slot + 1'b1;
  endfunction

endpackage

// File: rtl/cache_fill_responder_line_buffer.sv
// 8x16 line buffer: one write port, one read port with a registered,
// enable-gated output that holds its value when not read.
module fill_line_buffer
  import cache_fill_responder_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WORD_OFS_BITS-1:0] wr_slot,
  input  logic [15:0]              wr_data,
  input  logic                     rd_en,
  input  logic [WORD_OFS_BITS-1:0] rd_slot,
  output logic [15:0]              rd_data
);

  logic [15:0] line_mem [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_slot] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= line_mem[rd_slot];
    end
  end

endmodule

// File: rtl/cache_fill_responder.sv
// Serves cache line fills (critical-word-first fetch, gap-free 8-word stream)
// and single-word writes against a simple req/ack word backend.
module cache_fill_responder
  import cache_fill_responder_pkg::*;
#(
  parameter int ADDRW = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      cpu_addr,
  input  logic             sdram_req,
  input  logic             sdram_rw,
  input  logic             wr_uds_n,
  input  logic             wr_lds_n,
  input  logic [15:0]      data_to_sdram,
  output logic [15:0]      data_from_sdram,
  output logic             sdram_fill,
  output logic             sdram_wack,
  output logic [ADDRW-2:0] mem_addr,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_uds_n,
  output logic             mem_lds_n,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata,
  input  logic             mem_ack
);

  state_t state_reg, state_next;

  logic [WORD_OFS_BITS-1:0] cnt_reg;
  logic [ADDRW-2:0]         addr_reg;
  logic [15:0]              wdata_reg;
  logic                     uds_reg;
  logic                     lds_reg;
  logic                     wack_reg;

  logic                     fetch_ack;
  logic                     fetch_last;
  logic                     buf_wr_en;
  logic                     buf_rd_en;
  logic [WORD_OFS_BITS-1:0] buf_rd_slot;
  logic [15:0]              buf_rd_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDRW], cpu_addr[0]};

  assign fetch_ack  = (state_reg == FETCH) && mem_ack;
  assign fetch_last = fetch_ack && (cnt_reg == LAST_SLOT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (sdram_req) begin
          state_next = sdram_rw ? FETCH : WRITE;
        end
      end
      FETCH: begin
        if (fetch_last) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (cnt_reg == LAST_SLOT) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_next = WAITDROP;
        end
      end
      WAITDROP: begin
        if (!sdram_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic; the buffer read is issued one cycle ahead of each stream beat
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    sdram_fill  = 1'b0;
    buf_wr_en   = 1'b0;
    buf_rd_en   = 1'b0;
    buf_rd_slot = '0;
    case (state_reg)
      FETCH: begin
        mem_req   = 1'b1;
        buf_wr_en = mem_ack;
        buf_rd_en = fetch_last;
      end
      STREAM: begin
        sdram_fill  = 1'b1;
        buf_rd_en   = (cnt_reg != LAST_SLOT);
        buf_rd_slot = next_slot(cnt_reg);
      end
      WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: word counter, backend address and write payload
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      uds_reg   <= 1'b1;
      lds_reg   <= 1'b1;
      wack_reg  <= 1'b0;
    end else begin
      wack_reg <= (state_reg == WRITE) && mem_ack;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (sdram_req) begin
            addr_reg <= cpu_addr[ADDRW-1:1];
          end
          if (sdram_req && !sdram_rw) begin
            wdata_reg <= data_to_sdram;
            uds_reg   <= wr_uds_n;
            lds_reg   <= wr_lds_n;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            cnt_reg                           <= next_slot(cnt_reg);
            addr_reg[WORD_OFS_BITS-1:0]       <= next_slot(addr_reg[WORD_OFS_BITS-1:0]);
          end
        end
        STREAM: begin
          cnt_reg <= next_slot(cnt_reg);
        end
        WRITE: begin
          if (mem_ack) begin
            uds_reg <= 1'b1;
            lds_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fill_line_buffer u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr_en),
    .wr_slot (cnt_reg),
    .wr_data (mem_rdata),
    .rd_en   (buf_rd_en),
    .rd_slot (buf_rd_slot),
    .rd_data (buf_rd_data)
  );

  assign data_from_sdram = buf_rd_data;
  assign sdram_wack      = wack_reg;
  assign mem_addr        = addr_reg;
  assign mem_wdata       = wdata_reg;
  assign mem_uds_n       = uds_reg;
  assign mem_lds_n       = lds_reg;

endmodule

// File: tb/tb_cache_fill_responder.sv
// Directed bench: line fills (aligned and wrapped), write handshake,
// reset mid-fill and back-to-back fills against a req/ack memory model.
module tb_cache_fill_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic        sdram_req;
  logic        sdram_rw;
  logic        wr_uds_n;
  logic        wr_lds_n;
  logic [15:0] data_to_sdram;
  logic [15:0] data_from_sdram;
  logic        sdram_fill;
  logic        sdram_wack;
  logic [24:0] mem_addr;
  logic        mem_req;
  logic        mem_we;
  logic        mem_uds_n;
  logic        mem_lds_n;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int ack_gap   = 1;
  bit idx_mode  = 1'b1;
  bit force_ack = 1'b0;
  int wait_cnt  = 0;

  logic [24:0] addr_q[$];
  int          ackcyc_q[$];
  logic [15:0] fill_q[$];
  int          fillcyc_q[$];
  int          reqcyc_q[$];
  int          fill_total = 0;
  int          wack_cnt = 0;
  int          wackcyc = 0;
  logic        req_prev = 1'b0;

  cache_fill_responder dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_addr        (cpu_addr),
    .sdram_req       (sdram_req),
    .sdram_rw        (sdram_rw),
    .wr_uds_n        (wr_uds_n),
    .wr_lds_n        (wr_lds_n),
    .data_to_sdram   (data_to_sdram),
    .data_from_sdram (data_from_sdram),
    .sdram_fill      (sdram_fill),
    .sdram_wack      (sdram_wack),
    .mem_addr        (mem_addr),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_uds_n       (mem_uds_n),
    .mem_lds_n       (mem_lds_n),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: ack on the ack_gap-th cycle of a held request
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        wait_cnt++;
        if (wait_cnt >= ack_gap) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        wait_cnt = 0;
        mem_ack  = force_ack;
      end
      mem_rdata = idx_mode ? {13'd0, mem_addr[2:0]} : mem_addr[15:0];
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    #1;
    if (mem_req && mem_ack) begin
      addr_q.push_back(mem_addr);
      ackcyc_q.push_back(cyc);
    end
    if (sdram_fill) begin
      fill_q.push_back(data_from_sdram);
      fillcyc_q.push_back(cyc);
      fill_total++;
    end
    if (sdram_wack) begin
      wack_cnt++;
      wackcyc = cyc;
    end
    if (mem_req && !req_prev) reqcyc_q.push_back(cyc);
    req_prev = mem_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    ackcyc_q.delete();
    fill_q.delete();
    fillcyc_q.delete();
    reqcyc_q.delete();
    wack_cnt = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"},  {16'd0, data_from_sdram}, 32'h0);
    check({tag, "_fill"},  {31'd0, sdram_fill}, 32'h0);
    check({tag, "_wack"},  {31'd0, sdram_wack}, 32'h0);
    check({tag, "_req"},   {31'd0, mem_req}, 32'h0);
    check({tag, "_we"},    {31'd0, mem_we}, 32'h0);
    check({tag, "_addr"},  {7'd0, mem_addr}, 32'h0);
    check({tag, "_wdata"}, {16'd0, mem_wdata}, 32'h0);
    check({tag, "_uds"},   {31'd0, mem_uds_n}, 32'h1);
    check({tag, "_lds"},   {31'd0, mem_lds_n}, 32'h1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int gap, input bit idx);
    int n;
    clear_logs();
    ack_gap   = gap;
    idx_mode  = idx;
    cpu_addr  = addr;
    sdram_rw  = 1'b1;
    sdram_req = 1'b1;
    n = 0;
    while (fill_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    sdram_req = 1'b0;
    n = 0;
    while (fill_q.size() < 8 && n < 50) begin
      tick();
      n++;
    end
    $display("read addr=%h acks=%0d fills=%0d", addr, addr_q.size(), fill_q.size());
  endtask

  task automatic check_read(input string tag, input logic [24:0] base, input int crit, input bit idx);
    logic [24:0] ea;
    logic [2:0]  eofs;
    check({tag, "_nacks"}, addr_q.size(), 8);
    check({tag, "_nfill"}, fill_q.size(), 8);
    if (addr_q.size() == 8 && fill_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        eofs = 3'(crit + k);
        ea   = {base[24:3], eofs};
        check($sformatf("%s_addr%0d", tag, k), {7'd0, addr_q[k]}, {7'd0, ea});
        check($sformatf("%s_data%0d", tag, k), {16'd0, fill_q[k]},
              idx ? {29'd0, eofs} : {16'd0, ea[15:0]});
      end
      check({tag, "_latency"}, fillcyc_q[0] - ackcyc_q[7], 1);
      check({tag, "_contig"},  fillcyc_q[7] - fillcyc_q[0], 7);
    end
  endtask

  initial begin
    int n;
    int fill_base;
    int a_last;
    reset         = 1'b0;
    cpu_addr      = '0;
    sdram_req     = 1'b0;
    sdram_rw      = 1'b0;
    wr_uds_n      = 1'b1;
    wr_lds_n      = 1'b1;
    data_to_sdram = '0;
    repeat (3) tick();
    check_reset_values("por");
    reset = 1'b1;
    tick();

    // Aligned line, ack every cycle, data = word index
    do_read(32'h0000_0120, 1, 1'b1);
    check_read("rd_aligned", 25'h90, 0, 1'b1);
    repeat (3) tick();
    check("rd_aligned_hold", {16'd0, data_from_sdram}, 32'h7);

    // Critical word 7, ack every 3rd cycle, data = word address
    do_read(32'h0000_012E, 3, 1'b0);
    check_read("rd_wrap", 25'h90, 7, 1'b0);
    repeat (3) tick();

    // Single-word write with held request
    clear_logs();
    fill_base     = fill_total;
    ack_gap       = 4;
    cpu_addr      = 32'h0000_0200;
    data_to_sdram = 16'hA55A;
    wr_uds_n      = 1'b0;
    wr_lds_n      = 1'b1;
    sdram_rw      = 1'b0;
    sdram_req     = 1'b1;
    n = 0;
    while (!mem_req && n < 10) begin
      tick();
      n++;
    end
    check("wr_req",   {31'd0, mem_req}, 32'h1);
    check("wr_we",    {31'd0, mem_we}, 32'h1);
    check("wr_addr",  {7'd0, mem_addr}, 32'h100);
    check("wr_wdata", {16'd0, mem_wdata}, 32'hA55A);
    check("wr_uds",   {31'd0, mem_uds_n}, 32'h0);
    check("wr_lds",   {31'd0, mem_lds_n}, 32'h1);
    n = 0;
    while (wack_cnt == 0 && n < 20) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check("wr_nreq",  reqcyc_q.size(), 1);
    check("wr_nack",  addr_q.size(), 1);
    check("wr_nwack", wack_cnt, 1);
    if (ackcyc_q.size() == 1 && reqcyc_q.size() == 1) begin
      check("wr_ack_delay", ackcyc_q[0] - reqcyc_q[0], 3);
      check("wr_wack_cyc",  wackcyc - ackcyc_q[0], 1);
    end
    check("wr_we_drop", {31'd0, mem_we}, 32'h0);
    sdram_req = 1'b0;
    repeat (2) tick();
    check("wr_nfill", fill_total - fill_base, 0);
    $display("write addr=%h data=%h wacks=%0d", 32'h200, 16'hA55A, wack_cnt);
    wr_uds_n = 1'b1;

    // Reset after the third ack of a fill, with stray acks afterwards
    clear_logs();
    ack_gap   = 1;
    idx_mode  = 1'b1;
    cpu_addr  = 32'h0000_0120;
    sdram_rw  = 1'b1;
    sdram_req = 1'b1;
    n = 0;
    while (addr_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    reset     = 1'b0;
    sdram_req = 1'b0;
    force_ack = 1'b1;
    repeat (3) tick();
    check_reset_values("rst_in");
    reset = 1'b1;
    repeat (4) tick();
    check_reset_values("rst_out");
    check("rst_nfill", fill_q.size(), 0);
    force_ack = 1'b0;
    tick();
    $display("reset mid-fill acks_before=%0d fills=%0d", addr_q.size(), fill_q.size());

    // Back-to-back fills, second request 2 cycles after the first stream ends
    fill_base = fill_total;
    do_read(32'h0000_0120, 1, 1'b1);
    check_read("b2b_a", 25'h90, 0, 1'b1);
    a_last = (fillcyc_q.size() > 0) ? fillcyc_q[fillcyc_q.size()-1] : 0;
    repeat (2) tick();
    do_read(32'h0000_0346, 1, 1'b0);
    if (reqcyc_q.size() > 0) begin
      check("b2b_restart", reqcyc_q[0] - a_last, 3);
    end else begin
      check("b2b_restart", 0, 3);
    end
    repeat (5) tick();
    check_read("b2b_b", 25'h1A0, 3, 1'b0);
    check("b2b_fill_total", fill_total - fill_base, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_responder.md
CACHE_FILL_RESPONDER -- requirements
Module: cache_fill_responder

Interface
REQ-001 Parameter ADDRW, default 26, SHALL set the byte-address width served; word address is addr[ADDRW-1:1].
REQ-002 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 cpu_addr  in  32  request byte address; bits [ADDRW-1:1] used.
REQ-005 sdram_req  in  1  request from cache, level, held until served.
REQ-006 sdram_rw  in  1  1 = line read (fill), 0 = single-word write.
REQ-007 wr_uds_n / wr_lds_n  in  1 each  active-low byte enables for writes (upper = [15:8]).
REQ-008 data_to_sdram  in  16  write data.
REQ-009 data_from_sdram  out  16  fill data word.
REQ-010 sdram_fill  out  1  high on each of the 8 fill-stream cycles.
REQ-011 sdram_wack  out  1  one-cycle write-complete pulse.
REQ-012 mem_addr  out  ADDRW-1  backend word address.
REQ-013 mem_req, mem_we  out  1 each  backend request and write strobe.
REQ-014 mem_uds_n, mem_lds_n  out  1 each  backend byte enables.
REQ-015 mem_wdata  out  16;  mem_rdata  in  16;  mem_ack  in  1 (one-cycle pulse per word, rdata valid same cycle).

Function
REQ-016 States SHALL be IDLE, FETCH, STREAM, WRITE, WAITDROP.
REQ-017 IDLE: on sdram_req=1, sdram_rw=1 -> FETCH; sdram_rw=0 -> WRITE; otherwise remain.
REQ-018 A line SHALL be the 8 words sharing addr[ADDRW-1:4]; the critical word is addr[3:1].
REQ-019 FETCH SHALL read words in wrapped order (crit+k) mod 8, k=0..7; mem_req held high throughout, mem_addr advancing on the cycle after each mem_ack (back-to-back accepted).
REQ-020 The word returned with the k-th accepted mem_ack SHALL be stored in buffer slot k; mem_ack while mem_req=0 SHALL be ignored.
REQ-021 After the 8th mem_ack, mem_req SHALL drop next cycle and STREAM SHALL begin that cycle.
REQ-022 STREAM SHALL drive sdram_fill=1 and data_from_sdram=slot k for exactly 8 consecutive cycles, k=0..7, with no gaps, then return to IDLE.
REQ-023 sdram_req SHALL be ignored during FETCH and STREAM (the cache drops it after the first fill cycle).
REQ-024 Critical word 7 SHALL wrap: order 7,0,1,...,6 within the same line; no carry into addr[ADDRW-1:4].
REQ-025 WRITE SHALL drive mem_req=1, mem_we=1, mem_addr=cpu_addr word, mem_wdata=data_to_sdram, mem_uds_n/lds_n=wr_uds_n/lds_n until mem_ack, then drop mem_req/mem_we, pulse sdram_wack for one cycle, go to WAITDROP.
REQ-026 WAITDROP SHALL remain until sdram_req=0, then -> IDLE; no second write is issued for a held request.
REQ-027 Fill latency: first sdram_fill cycle SHALL be exactly 1 cycle after the 8th mem_ack.
REQ-028 Outside STREAM, sdram_fill SHALL be 0; data_from_sdram SHALL hold its last value.

Reset
REQ-029 reset=0 SHALL force IDLE from any state, including mid-FETCH, mid-STREAM and mid-WRITE, abandoning the transaction.
REQ-030 Reset values: data_from_sdram=0, sdram_fill=0, sdram_wack=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_uds_n=1, mem_lds_n=1, word counter=0.
REQ-031 mem_ack arriving during or after reset for an abandoned request SHALL be ignored.

Structure
REQ-032 Shared package SHALL hold LINE_WORDS=8, WORD_OFS_BITS=3 and the state encodings.
REQ-033 The 8x16 line buffer SHALL be a sub-module fill_line_buffer (write port slot/data/en, read port slot).

Verification
REQ-034 Read addr 0x000120, mem_ack every cycle, mem_rdata=word index -> fill stream 0,1,...,7 on 8 consecutive cycles, first one cycle after 8th ack.
REQ-035 Read addr 0x00012E (crit=7), mem_ack every 3rd cycle -> mem_addr sequence 0x97,0x90..0x96; fill stream data in that order, gap-free.
REQ-036 Write addr 0x000200, data 0xA55A, wr_uds_n=0, wr_lds_n=1, ack after 4 cycles -> mem_we=1, mem_uds_n=0, mem_lds_n=1, mem_wdata=0xA55A; one sdram_wack pulse; held sdram_req for 10 cycles produces no second mem_req.
REQ-037 Assert reset=0 after 3rd mem_ack of a fill, then stray mem_ack -> all outputs at reset values, no sdram_fill, state IDLE.
REQ-038 Two back-to-back reads (second req raised 2 cycles after stream ends) -> second FETCH starts from IDLE, both streams exactly 8 cycles, sdram_fill never high outside STREAM.
